// File: rtl/video_row_streamer_pkg.sv
// Shared types and default sizes for the row streamer.
package video_row_streamer_pkg;

    localparam int unsigned DefXSize  = 1280;
    localparam int unsigned DefYSize  = 720;
    localparam int unsigned DefXWidth = 11;
    localparam int unsigned DefYWidth = 10;

    localparam logic [23:0] DefAliveColour = 24'hFFFFFF;
    localparam logic [23:0] DefDeadColour  = 24'h000000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StStream
    } stream_state_e;

endpackage

// File: rtl/row_double_buffer.sv
// Current/next row registers with swap and per-pixel bit select.
module row_double_buffer #(
    parameter int unsigned X_SIZE  = 1280,
    parameter int unsigned X_WIDTH = 11
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_cur_i,
    input  logic               load_nxt_i,
    input  logic               swap_i,
    input  logic [X_SIZE-1:0]  row_data_i,
    input  logic [X_WIDTH-1:0] sel_i,
    output logic               bit_o
);

    logic [X_SIZE-1:0] cur_q;
    logic [X_SIZE-1:0] nxt_q;

    // Row registers: first row loads straight into current, later rows go via next.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_q <= '0;
            nxt_q <= '0;
        end else begin
            if (load_cur_i) begin
                cur_q <= row_data_i;
            end else if (swap_i) begin
                cur_q <= nxt_q;
            end
            if (load_nxt_i) begin
                nxt_q <= row_data_i;
            end
        end
    end

    // LSB of the row is pixel 0.
    always_comb begin
        bit_o = cur_q[sel_i];
    end

endmodule

// File: rtl/video_row_streamer.sv
// Streams a frame of cell bits from row memory as an RGB pixel stream.
module video_row_streamer
    import video_row_streamer_pkg::*;
#(
    parameter int unsigned X_SIZE       = DefXSize,
    parameter int unsigned Y_SIZE       = DefYSize,
    parameter int unsigned X_WIDTH      = DefXWidth,
    parameter int unsigned Y_WIDTH      = DefYWidth,
    parameter logic [23:0] ALIVE_COLOUR = DefAliveColour,
    parameter logic [23:0] DEAD_COLOUR  = DefDeadColour
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    output logic [Y_WIDTH-1:0] video_out_row_addr,
    input  logic [X_SIZE-1:0]  video_out_row_data,
    output logic [23:0]        m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tuser,
    output logic               m_tlast,
    output logic               frame_done
);

    localparam logic [X_WIDTH-1:0] XLast = X_WIDTH'(X_SIZE - 1);
    localparam logic [Y_WIDTH-1:0] YLast = Y_WIDTH'(Y_SIZE - 1);

    stream_state_e      state_q, state_d;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q, y_inc;
    logic [Y_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]         pf_q;
    logic               pf_start;
    logic               frame_done_q;
    logic               xfer, row_end, frame_end;
    logic               pix_bit;

    assign xfer      = m_tvalid & m_tready;
    assign row_end   = xfer & (x_q == XLast);
    assign frame_end = row_end & (y_q == YLast);
    assign y_inc     = y_q + Y_WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; en only matters while idle or at the end of a frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (en) state_d = StFetch;
            StFetch:   state_d = StCapture;
            StCapture: state_d = StStream;
            StStream:  if (frame_end) state_d = en ? StFetch : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Stream outputs are decoded from state, counters and the current row.
    always_comb begin
        m_tvalid = (state_q == StStream);
        m_tuser  = m_tvalid && (x_q == '0) && (y_q == '0);
        m_tlast  = m_tvalid && (x_q == XLast);
        m_tdata  = '0;
        if (m_tvalid) begin
            m_tdata = pix_bit ? ALIVE_COLOUR : DEAD_COLOUR;
        end
    end

    // Row address: row 0 on frame start, y+1 prefetch on entry to each non-final row.
    always_comb begin
        addr_d   = addr_q;
        pf_start = 1'b0;
        if (en && ((state_q == StIdle) || frame_end)) begin
            addr_d = '0;
        end else if ((state_q == StCapture) && (YLast != '0)) begin
            addr_d   = Y_WIDTH'(1);
            pf_start = 1'b1;
        end else if (row_end && !frame_end && (y_inc != YLast)) begin
            addr_d   = y_inc + Y_WIDTH'(1);
            pf_start = 1'b1;
        end
    end

    // Counters, address register, prefetch pipeline and frame_done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            pf_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            pf_q         <= {pf_q[0], pf_start};
            frame_done_q <= frame_end;
            if (xfer) begin
                if (row_end) begin
                    x_q <= '0;
                    y_q <= frame_end ? '0 : y_inc;
                end else begin
                    x_q <= x_q + X_WIDTH'(1);
                end
            end
        end
    end

    assign video_out_row_addr = addr_q;
    assign frame_done         = frame_done_q;

    // pf_q[1]: memory word for the prefetched address is on the data port now.
    row_double_buffer #(
        .X_SIZE  (X_SIZE),
        .X_WIDTH (X_WIDTH)
    ) u_row_buf (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .load_cur_i (state_q == StCapture),
        .load_nxt_i (pf_q[1]),
        .swap_i     (row_end && !frame_end),
        .row_data_i (video_out_row_data),
        .sel_i      (x_q),
        .bit_o      (pix_bit)
    );

endmodule

// File: tb/tb_video_row_streamer.sv
// Directed bench for video_row_streamer on an 8x4 frame.
module tb_video_row_streamer;

    localparam int unsigned XS = 8;
    localparam int unsigned YS = 4;
    localparam logic [23:0] ALIVE = 24'hFFFFFF;
    localparam logic [23:0] DEAD  = 24'h202020;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [1:0]  row_addr;
    logic [7:0]  row_data;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tuser;
    logic        m_tlast;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Row memory: row y holds a single set bit at position y, one cycle read latency.
    always @(posedge clk) row_data <= 8'(8'h01 << row_addr);

    video_row_streamer #(
        .X_SIZE       (XS),
        .Y_SIZE       (YS),
        .X_WIDTH      (3),
        .Y_WIDTH      (2),
        .ALIVE_COLOUR (ALIVE),
        .DEAD_COLOUR  (DEAD)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .en                 (en),
        .video_out_row_addr (row_addr),
        .video_out_row_data (row_data),
        .m_tdata            (m_tdata),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .m_tuser            (m_tuser),
        .m_tlast            (m_tlast),
        .frame_done         (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_pix(input int k);
        return ((k % 8) == (k / 8)) ? ALIVE : DEAD;
    endfunction

    // mode 0: ready high; 1: ready toggles; 2: ready low 10 cycles at x=7,y=1.
    // drop_k >= 0 drops en when that transfer index is presented.
    task automatic run_frame(input int mode, input int drop_k);
        int k;
        int cyc;
        int stall;
        bit phase;
        bit held;
        logic [23:0] hd;
        logic hu;
        logic hl;
        k = 0; cyc = 0; stall = 0; phase = 1'b0; held = 1'b0;
        hd = '0; hu = 1'b0; hl = 1'b0;
        while (k < 32 && cyc < 400) begin
            case (mode)
                1: begin
                    m_tready = phase;
                    phase = ~phase;
                end
                2: begin
                    if (k == 15 && stall < 10) begin
                        m_tready = 1'b0;
                        stall++;
                        chk("stall_tlast", {31'd0, m_tlast}, 32'd1);
                    end else begin
                        m_tready = 1'b1;
                    end
                end
                default: m_tready = 1'b1;
            endcase
            if (k == drop_k) en = 1'b0;
            chk("fd_quiet", {31'd0, frame_done}, 32'd0);
            if (mode == 0 && k > 0) chk("no_bubble", {31'd0, m_tvalid}, 32'd1);
            if (held) begin
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("hold_tdata", {8'd0, m_tdata}, {8'd0, hd});
                chk("hold_tuser", {31'd0, m_tuser}, {31'd0, hu});
                chk("hold_tlast", {31'd0, m_tlast}, {31'd0, hl});
            end
            if (m_tvalid) begin
                if (m_tready) begin
                    chk($sformatf("tdata_k%0d", k), {8'd0, m_tdata}, {8'd0, exp_pix(k)});
                    chk($sformatf("tuser_k%0d", k), {31'd0, m_tuser}, {31'd0, k == 0});
                    chk($sformatf("tlast_k%0d", k), {31'd0, m_tlast}, {31'd0, (k % 8) == 7});
                    k++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = m_tdata;
                    hu = m_tuser;
                    hl = m_tlast;
                end
            end
            tick();
            cyc++;
        end
        chk("frame_complete", k, 32);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        tick();
        chk("frame_done_single", {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        resetn = 1'b0;
        en = 1'b0;
        m_tready = 1'b0;
        tick();
        tick();
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tuser", {31'd0, m_tuser}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", {8'd0, m_tdata}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_addr", {30'd0, row_addr}, 32'd0);
        resetn = 1'b1;
        tick();

        // Latency: valid appears three cycles after en is seen in idle.
        en = 1'b1;
        m_tready = 1'b1;
        chk("lat_c0", {31'd0, m_tvalid}, 32'd0);
        tick();
        chk("lat_c1", {31'd0, m_tvalid}, 32'd0);
        chk("fetch_addr", {30'd0, row_addr}, 32'd0);
        tick();
        chk("lat_c2", {31'd0, m_tvalid}, 32'd0);
        tick();
        chk("lat_c3", {31'd0, m_tvalid}, 32'd1);
        chk("first_tuser", {31'd0, m_tuser}, 32'd1);
        chk("first_tdata", {8'd0, m_tdata}, {8'd0, ALIVE});
        chk("prefetch_addr", {30'd0, row_addr}, 32'd1);
        run_frame(0, -1);

        run_frame(1, -1);
        run_frame(2, -1);

        // en dropped at x=3, y=1: frame still completes, then idle.
        run_frame(0, 11);
        for (int i = 0; i < 5; i++) begin
            chk("idle_tvalid", {31'd0, m_tvalid}, 32'd0);
            tick();
        end

        // Reset at x=5, y=2 with en held high.
        en = 1'b1;
        m_tready = 1'b1;
        k = 0;
        cyc = 0;
        while (!(m_tvalid && k == 21) && cyc < 100) begin
            if (m_tvalid && m_tready) k++;
            tick();
            cyc++;
        end
        chk("reach_x5y2", k, 21);
        chk("x5y2_tdata", {8'd0, m_tdata}, {8'd0, DEAD});
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_rst_tdata", {8'd0, m_tdata}, 32'd0);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        chk("mid_rst_addr", {30'd0, row_addr}, 32'd0);
        run_frame(0, -1);

        en = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
